mem_view_ctrl: RTL and testbench

Memory-browse controller feeding the 4-digit seven-segment display driver. It debounces two push-buttons, steps a word address through the data memory, issues a single read per step, and captures the returned word. It presents a 32-bit display value whose low 16 bits hold the selected half-word of the captured data and whose high 16 bits hold the current address. It sits between the board buttons and switches, the memory read port, and the display's 32-bit `s` input.

---
 rtl/mem_view_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_mem_view_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_view_ctrl.sv
// mem_view_ctrl
// Memory-browse controller for the 4-digit seven-segment display.
// Two debounced push-buttons step a word address through data memory.
// Each step issues one read, and the returned word is captured.
// The display shows {address, selected half-word of the captured data}.
//
// Ports:
//   clk, reset       system clock, asynchronous active-high reset
//   btn_next         raw button, step address +1
//   btn_prev         raw button, step address -1
//   sw_half          raw switch, 0 selects data[15:0], 1 selects data[31:16]
//   rd_en, rd_addr   memory read strobe (one cycle per read) and word address
//   rd_data          memory read data, qualified by rd_valid
//   rd_valid         read-data qualifier, honoured only while waiting for a read
//   disp_value       {zero-extended rd_addr, selected half-word}, drives display s
//   busy             high while booting, requesting or waiting
//   err              last read timed out
//
// Optional feature: define MEM_VIEW_AUTOSCAN_EN to inject a "next" press
// every AUTO_CYC idle cycles.

module mem_view_ctrl #(
    parameter int ADDR_W       = 6,
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int TIMEOUT_CYC  = 16,
    parameter int AUTO_CYC     = 100_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_next,
    input  logic              btn_prev,
    input  logic              sw_half,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       rd_data,
    input  logic              rd_valid,
    output logic [31:0]       disp_value,
    output logic              busy,
    output logic              err
);

    localparam int DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {BOOT, IDLE, REQ, WAIT} state_t;

    state_t            state;
    logic [2:0]        sync1;
    logic [2:0]        sync2;
    logic [1:0]        deb;
    logic [1:0]        deb_d;
    logic [DB_W-1:0]   db_cnt [2];
    logic [1:0]        press_pulse;
    logic              press_valid;
    logic              press_dir;
    logic              step_valid;
    logic              step_dir;
    logic              pend_valid;
    logic              pend_dir;
    logic [TO_W-1:0]   wait_cnt;
    logic [31:0]       data_reg;

    // Bit order in the synchronizer: [0] btn_next, [1] btn_prev, [2] sw_half.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {sw_half, btn_prev, btn_next};
            sync2 <= sync1;
        end
    end

    // The count runs only while the synchronized level disagrees with the
    // accepted level; any agreement restarts it, so a flip needs
    // DEBOUNCE_CYC consecutive disagreeing cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb   <= '0;
            deb_d <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            deb_d <= deb;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] != deb[i]) begin
                    if (db_cnt[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
                        deb[i]    <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // Simultaneous next and prev presses cancel each other.
    assign press_pulse = deb & ~deb_d;
    assign press_valid = press_pulse[0] ^ press_pulse[1];
    assign press_dir   = press_pulse[0];

`ifdef MEM_VIEW_AUTOSCAN_EN
    localparam int AUTO_W = (AUTO_CYC > 1) ? $clog2(AUTO_CYC) : 1;

    logic [AUTO_W-1:0] auto_cnt;
    logic              auto_fire;

    assign auto_fire = (state == IDLE) && (auto_cnt == AUTO_W'(AUTO_CYC - 1));

    // Counts idle time only; a manual press restarts the period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            auto_cnt <= '0;
        end else if (press_valid || auto_fire) begin
            auto_cnt <= '0;
        end else if (state == IDLE) begin
            auto_cnt <= auto_cnt + 1'b1;
        end
    end

    assign step_valid = press_valid | auto_fire;
    assign step_dir   = press_valid ? press_dir : 1'b1;
`else
    logic unused_auto_cfg;
    assign unused_auto_cfg = (AUTO_CYC == 0);
    assign step_valid      = press_valid;
    assign step_dir        = press_dir;
`endif

    // Presses arriving while a read is in flight land in a one-deep slot,
    // newest wins; the slot is served ahead of any new press once idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= BOOT;
            rd_addr    <= '0;
            rd_en      <= 1'b0;
            busy       <= 1'b1;
            err        <= 1'b0;
            data_reg   <= '0;
            pend_valid <= 1'b0;
            pend_dir   <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            rd_en <= 1'b0;
            if (state != IDLE && step_valid) begin
                pend_valid <= 1'b1;
                pend_dir   <= step_dir;
            end
            case (state)
                BOOT: begin
                    state <= REQ;
                    rd_en <= 1'b1;
                    busy  <= 1'b1;
                end
                IDLE: begin
                    if (pend_valid) begin
                        pend_valid <= 1'b0;
                        rd_addr    <= pend_dir ? rd_addr + 1'b1 : rd_addr - 1'b1;
                        state      <= REQ;
                        rd_en      <= 1'b1;
                        busy       <= 1'b1;
                    end else if (step_valid) begin
                        rd_addr <= step_dir ? rd_addr + 1'b1 : rd_addr - 1'b1;
                        state   <= REQ;
                        rd_en   <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                REQ: begin
                    state    <= WAIT;
                    wait_cnt <= '0;
                end
                WAIT: begin
                    if (rd_valid) begin
                        data_reg <= rd_data;
                        err      <= 1'b0;
                        state    <= IDLE;
                        busy     <= 1'b0;
                    end else if (wait_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                        data_reg <= 32'hEEEE_EEEE;
                        err      <= 1'b1;
                        state    <= IDLE;
                        busy     <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp_value <= '0;
        end else begin
            disp_value <= {16'(rd_addr), sync2[2] ? data_reg[31:16] : data_reg[15:0]};
        end
    end

endmodule

// File: tb/tb_mem_view_ctrl.sv
// Testbench for mem_view_ctrl: randomized browsing against a reference model
// of the address / captured-data / error behaviour, plus directed boundary cases.

module tb_mem_view_ctrl;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int DEB    = 4;
    localparam int TO     = 24;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              btn_next = 1'b0;
    logic              btn_prev = 1'b0;
    logic              sw_half = 1'b0;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [31:0]       rd_data;
    logic              rd_valid;
    logic [31:0]       disp_value;
    logic              busy;
    logic              err;

    int                checks = 0;
    int                failures = 0;
    logic [31:0]       mem [DEPTH];
    int                mem_lat = 1;
    logic              inject = 1'b0;
    int                rd_count = 0;
    logic [ADDR_W-1:0] last_rd_addr = '0;

    int                exp_addr;
    logic [31:0]       exp_data;
    logic              exp_err;

    mem_view_ctrl #(
        .ADDR_W      (ADDR_W),
        .DEBOUNCE_CYC(DEB),
        .TIMEOUT_CYC (TO),
        .AUTO_CYC    (1000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_next  (btn_next),
        .btn_prev  (btn_prev),
        .sw_half   (sw_half),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .disp_value(disp_value),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Memory answers mem_lat cycles after seeing rd_en (0 = never answers).
    initial begin : memModel
        int remain;
        remain   = 0;
        rd_valid = 1'b0;
        rd_data  = '0;
        forever begin
            @(negedge clk);
            rd_valid = 1'b0;
            rd_data  = $urandom;
            if (reset) begin
                remain = 0;
            end else begin
                if (rd_en) begin
                    rd_count++;
                    last_rd_addr = rd_addr;
                end
                if (inject) begin
                    rd_valid = 1'b1;
                end else if (remain > 0) begin
                    remain--;
                    if (remain == 0) begin
                        rd_valid = 1'b1;
                        rd_data  = mem[last_rd_addr];
                    end
                end else if (rd_en && mem_lat > 0) begin
                    remain = mem_lat;
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] expDisp(input int a, input logic [31:0] d, input logic sw);
        logic [15:0] a16;
        a16 = 16'(a);
        return {a16, sw ? d[31:16] : d[15:0]};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // dir: 0 next, 1 prev, 2 both
    task automatic applyStimulus(input int dir, input int hi, input int lo);
        @(negedge clk);
        if (dir == 0 || dir == 2) btn_next = 1'b1;
        if (dir == 1 || dir == 2) btn_prev = 1'b1;
        repeat (hi) @(negedge clk);
        btn_next = 1'b0;
        btn_prev = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic doStep(input int dir, input int lat);
        int base;
        int n;
        int len;
        bit tmo;
        mem_lat  = lat;
        base     = rd_count;
        tmo      = (lat == 0) || (lat > TO);
        exp_addr = (dir == 0) ? (exp_addr + 1) % DEPTH : (exp_addr + DEPTH - 1) % DEPTH;
        exp_data = tmo ? 32'hEEEE_EEEE : mem[exp_addr];
        exp_err  = tmo;
        n   = 0;
        len = 0;
        fork
            applyStimulus(dir, 10 + int'($urandom_range(0, 3)), 8);
            begin
                while (!rd_en && n < 80) begin
                    @(negedge clk);
                    n++;
                end
                while (busy && len < 100) begin
                    @(negedge clk);
                    len++;
                end
                @(negedge clk);
                checkOutput("step_disp", disp_value, expDisp(exp_addr, exp_data, sw_half));
            end
        join
        checkOutput("step_reads", 32'(rd_count - base), 32'd1);
        checkOutput("step_rd_addr", 32'(last_rd_addr), 32'(exp_addr));
        checkOutput("step_busy_len", 32'(len), tmo ? 32'(TO + 1) : 32'(lat + 1));
        checkOutput("step_err", 32'(err), 32'(exp_err));
        repeat (4) @(negedge clk);
        checkOutput("step_disp_hold", disp_value, expDisp(exp_addr, exp_data, sw_half));
    endtask

    initial begin : main
        int base;
        int n;
        int lat;
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        mem[0] = 32'h1234_5678;

        // Reset state
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_rd_en", 32'(rd_en), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd1);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_disp", disp_value, 32'd0);
        checkOutput("rst_rd_addr", 32'(rd_addr), 32'd0);

        // Boot fetch of address 0 with 1-cycle memory
        mem_lat = 1;
        base    = rd_count;
        reset   = 1'b0;
        @(negedge clk);
        checkOutput("boot_rd_en", 32'(rd_en), 32'd1);
        checkOutput("boot_rd_addr", 32'(rd_addr), 32'd0);
        @(negedge clk);
        checkOutput("boot_rd_en_low", 32'(rd_en), 32'd0);
        @(negedge clk);
        checkOutput("boot_busy", 32'(busy), 32'd0);
        @(negedge clk);
        checkOutput("boot_disp", disp_value, 32'h0000_5678);
        checkOutput("boot_reads", 32'(rd_count - base), 32'd1);
        exp_addr = 0;
        exp_data = mem[0];
        exp_err  = 1'b0;

        // Switch reaches display three cycles later
        sw_half = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("sw_early", disp_value, 32'h0000_5678);
        @(negedge clk);
        checkOutput("sw_late", disp_value, 32'h0000_1234);
        sw_half = 1'b0;

        // Wrap below zero, timeout, recovery, and WAIT-window boundaries
        doStep(1, 1);
        doStep(0, 0);
        doStep(0, 2);
        doStep(1, TO);
        doStep(0, TO + 1);

        // Short glitch and cancelling presses give no read
        base = rd_count;
        applyStimulus(0, 3, 12);
        checkOutput("glitch_reads", 32'(rd_count - base), 32'd0);
        checkOutput("glitch_addr", 32'(rd_addr), 32'(exp_addr));
        applyStimulus(2, 10, 10);
        checkOutput("cancel_reads", 32'(rd_count - base), 32'd0);
        checkOutput("cancel_addr", 32'(rd_addr), 32'(exp_addr));

        // rd_valid while idle is ignored
        @(posedge clk);
        inject = 1'b1;
        @(posedge clk);
        inject = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("idle_valid_disp", disp_value, expDisp(exp_addr, exp_data, sw_half));
        checkOutput("idle_valid_busy", 32'(busy), 32'd0);

        // Two presses during a long WAIT collapse into one follow-up read
        mem_lat = 0;
        base    = rd_count;
        n       = 0;
        fork
            begin
                applyStimulus(0, 5, 5);
                applyStimulus(0, 5, 5);
                applyStimulus(0, 5, 8);
            end
            begin
                while (rd_count - base < 1 && n < 80) begin
                    @(negedge clk);
                    n++;
                end
                mem_lat = 1;
            end
        join
        n = 0;
        while (!((rd_count - base) >= 2 && !busy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (12) @(negedge clk);
        exp_addr = (exp_addr + 2) % DEPTH;
        exp_data = mem[exp_addr];
        exp_err  = 1'b0;
        checkOutput("pend_reads", 32'(rd_count - base), 32'd2);
        checkOutput("pend_rd_addr", 32'(last_rd_addr), 32'(exp_addr));
        checkOutput("pend_disp", disp_value, expDisp(exp_addr, exp_data, sw_half));
        checkOutput("pend_err", 32'(err), 32'd0);

        // Reset during WAIT drops the read; boot fetch follows release
        mem_lat = 0;
        base    = rd_count;
        applyStimulus(0, 10, 8);
        checkOutput("rstw_busy_pre", 32'(busy), 32'd1);
        checkOutput("rstw_reads_pre", 32'(rd_count - base), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("rstw_rd_en", 32'(rd_en), 32'd0);
        checkOutput("rstw_disp", disp_value, 32'd0);
        checkOutput("rstw_rd_addr", 32'(rd_addr), 32'd0);
        repeat (2) @(negedge clk);
        mem_lat = 1;
        reset   = 1'b0;
        @(negedge clk);
        checkOutput("rstw_boot_rd_en", 32'(rd_en), 32'd1);
        checkOutput("rstw_boot_addr", 32'(rd_addr), 32'd0);
        repeat (3) @(negedge clk);
        exp_addr = 0;
        exp_data = mem[0];
        exp_err  = 1'b0;
        checkOutput("rstw_boot_disp", disp_value, expDisp(0, exp_data, sw_half));
        checkOutput("rstw_boot_busy", 32'(busy), 32'd0);

        // Random browsing
        for (int it = 0; it < 16; it++) begin
            sw_half = 1'($urandom_range(0, 1));
            lat     = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 8));
            doStep(int'($urandom_range(0, 1)), lat);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
